// File: rtl/mem_if_pkg.sv
// Shared definitions for the data memory controller: bus widths, the value
// loaded on a timed-out read, and the controller FSM state type.
package mem_if_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/data_mem_controller_if.sv
// Bundle of core-side and memory-side signals of the data memory controller.
//   slave  : controller view (core requests + memory ack/data in; stall,
//            load result, errors and memory request out)
//   master : environment view (core and external memory), directions reversed
interface data_mem_controller_if;
    import mem_if_pkg::*;

    // core side
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] DataMemOut;
    logic              MemStall;
    logic              BusErr;
    logic              ProtoErr;

    // memory side
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemAck;
    logic [DATA_W-1:0] MemRData;

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData, MemAck, MemRData,
        output DataMemOut, MemStall, BusErr, ProtoErr,
               MemReq, MemWe, MemAddr, MemWData
    );

    modport master (
        output MemRead, MemWrite, Addr, WriteData, MemAck, MemRData,
        input  DataMemOut, MemStall, BusErr, ProtoErr,
               MemReq, MemWe, MemAddr, MemWData
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a memory acknowledge.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count from zero
//   enable   : count this cycle (saturates at 8'hFF)
//   expired  : current cycle is the TIMEOUT-th counted cycle (or later)
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count holds the number of already-completed wait cycles, so the
    // TIMEOUT-th wait cycle is the one where count == TIMEOUT-1.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/data_mem_controller.sv
// Load/store controller between the core memory stage and a handshaked data
// memory. Stalls the core while an access is in flight, registers load data
// for write-back, and flags timeouts (BusErr) and read+write requests
// (ProtoErr).
//   CLK, Reset : clock, asynchronous active-high reset
//   bus        : data_mem_controller_if.slave (core and memory signals)
module data_mem_controller
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  Reset,
    data_mem_controller_if.slave  bus
);

    mem_state_t state, state_next;

    logic              start;
    logic              both_req;
    logic              expired;
    logic              finish;
    logic              op_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              bus_err_q;
    logic              proto_err_q;

    assign start    = (state == IDLE) && (bus.MemRead ^ bus.MemWrite);
    assign both_req = (state == IDLE) && bus.MemRead && bus.MemWrite;
    // Ack wins over expiry when both land in the last wait cycle.
    assign finish   = (state == REQ) && (bus.MemAck || expired);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst     (Reset),
        .clear   (state == IDLE),
        .enable  (state == REQ),
        .expired (expired)
    );

    // state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)  state_next = REQ;
            REQ:     if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs decoded from state; memory outputs are zero outside REQ
    always_comb begin
        bus.MemStall = 1'b0;
        bus.MemReq   = 1'b0;
        bus.MemWe    = 1'b0;
        bus.MemAddr  = '0;
        bus.MemWData = '0;
        unique case (state)
            IDLE: bus.MemStall = start;
            REQ: begin
                bus.MemStall = 1'b1;
                bus.MemReq   = 1'b1;
                bus.MemWe    = op_we_q;
                bus.MemAddr  = addr_q;
                bus.MemWData = wdata_q;
            end
            default: ;
        endcase
    end

    // request latch, load result and error pulses
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (start) begin
                op_we_q <= bus.MemWrite;
                addr_q  <= bus.Addr;
                wdata_q <= bus.WriteData;
            end
            if (finish && !op_we_q) begin
                rdata_q <= bus.MemAck ? bus.MemRData : BUS_ERR_DATA;
            end
            bus_err_q   <= finish && !bus.MemAck;
            proto_err_q <= both_req;
        end
    end

    assign bus.DataMemOut = rdata_q;
    assign bus.BusErr     = bus_err_q;
    assign bus.ProtoErr   = proto_err_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller. Each memory instruction is
// modelled as a transaction: from the ack delay the bench derives how many
// cycles the request is outstanding, whether it times out, and the resulting
// load value, then checks every cycle of the transaction against that.
module tb_data_mem_controller;

    localparam int TIMEOUT = 15;

    logic CLK;
    logic Reset;

    data_mem_controller_if bus ();

    data_mem_controller #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_dout = 8'h00;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle_inputs();
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Addr      = 8'($urandom);
        bus.WriteData = 8'($urandom);
        bus.MemAck    = 1'($urandom);
        bus.MemRData  = 8'($urandom);
    endtask

    // One idle cycle; proto_exp is the ProtoErr value expected in it.
    task automatic idle_cycle(input bit proto_exp);
        @(posedge CLK); #1;
        drive_idle_inputs();
        @(negedge CLK);
        check("idle stall", bus.MemStall, 0);
        check("idle req",   bus.MemReq,   0);
        check("idle we",    bus.MemWe,    0);
        check("idle addr",  bus.MemAddr,  0);
        check("idle wdata", bus.MemWData, 0);
        check("idle buserr", bus.BusErr,  0);
        check("idle proto", bus.ProtoErr, 32'(proto_exp));
        check("idle dout",  bus.DataMemOut, 32'(exp_dout));
    endtask

    // One memory instruction. d = number of wait cycles before ack (ack in
    // REQ cycle d+1); d < 0 means the memory never answers.
    task automatic do_access(input bit we, input logic [7:0] a, input logic [7:0] wd,
                             input int d, input logic [7:0] rd);
        bit         to;
        int         n;
        logic [7:0] nxt;
        to  = (d < 0) || (d + 1 > TIMEOUT);
        n   = to ? TIMEOUT : d + 1;
        nxt = we ? exp_dout : (to ? 8'hFF : rd);
        for (int c = 0; c <= n + 1; c++) begin
            @(posedge CLK); #1;
            if (c <= n) begin
                bus.MemRead   = !we;
                bus.MemWrite  = we;
                bus.Addr      = a;
                bus.WriteData = wd;
            end else begin
                bus.MemRead   = 1'($urandom);
                bus.MemWrite  = 1'($urandom);
                bus.Addr      = 8'($urandom);
                bus.WriteData = 8'($urandom);
            end
            if (d >= 0 && c == d + 1) begin
                bus.MemAck   = 1'b1;
                bus.MemRData = rd;
            end else begin
                bus.MemAck   = (c == 0 || c == n + 1) ? 1'($urandom) : 1'b0;
                bus.MemRData = 8'($urandom);
            end
            @(negedge CLK);
            check($sformatf("stall a%0h c%0d", a, c), bus.MemStall, 32'(c <= n));
            check($sformatf("req a%0h c%0d", a, c), bus.MemReq, 32'(c >= 1 && c <= n));
            if (c >= 1 && c <= n) begin
                check($sformatf("we a%0h c%0d", a, c), bus.MemWe, 32'(we));
                check($sformatf("maddr a%0h c%0d", a, c), bus.MemAddr, 32'(a));
                if (we) check($sformatf("mwdata a%0h c%0d", a, c), bus.MemWData, 32'(wd));
            end
            check($sformatf("buserr a%0h c%0d", a, c), bus.BusErr, 32'(to && c == n + 1));
            check($sformatf("proto a%0h c%0d", a, c), bus.ProtoErr, 0);
            check($sformatf("dout a%0h c%0d", a, c), bus.DataMemOut,
                  32'((c == n + 1) ? nxt : exp_dout));
        end
        exp_dout = nxt;
    endtask

    initial begin
        Reset = 1'b1;
        drive_idle_inputs();
        bus.MemAck = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst stall", bus.MemStall, 0);
        check("rst req",   bus.MemReq,   0);
        check("rst we",    bus.MemWe,    0);
        check("rst addr",  bus.MemAddr,  0);
        check("rst wdata", bus.MemWData, 0);
        check("rst buserr", bus.BusErr,  0);
        check("rst proto", bus.ProtoErr, 0);
        check("rst dout",  bus.DataMemOut, 0);
        Reset = 1'b0;
        idle_cycle(1'b0);

        // minimum-latency read, write with 3 wait cycles, timed-out read
        do_access(1'b0, 8'h3C, 8'h00, 0, 8'hA5);
        do_access(1'b1, 8'h7E, 8'h11, 3, 8'h00);
        do_access(1'b0, 8'h55, 8'h00, -1, 8'h00);
        idle_cycle(1'b0);

        // read and write simultaneously in IDLE
        @(posedge CLK); #1;
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.Addr      = 8'h22;
        bus.WriteData = 8'h33;
        bus.MemAck    = 1'b0;
        @(negedge CLK);
        check("proto stall", bus.MemStall, 0);
        check("proto req",   bus.MemReq,   0);
        check("proto early", bus.ProtoErr, 0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // back-to-back reads
        do_access(1'b0, 8'h01, 8'h00, 0, 8'h10);
        do_access(1'b0, 8'h02, 8'h00, 0, 8'h20);

        // ack exactly in the last allowed wait cycle, then one cycle too late
        do_access(1'b0, 8'h90, 8'h00, TIMEOUT - 1, 8'h5A);
        do_access(1'b0, 8'h91, 8'h00, TIMEOUT, 8'h6B);
        do_access(1'b1, 8'h92, 8'h77, -1, 8'h00);
        do_access(1'b0, 8'h93, 8'h00, 1, 8'hC3);

        // reset in the middle of a read
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            bus.MemRead  = 1'b1;
            bus.MemWrite = 1'b0;
            bus.Addr     = 8'h40;
            bus.MemAck   = 1'b0;
        end
        @(negedge CLK);
        check("pre-rst req", bus.MemReq, 1);
        @(posedge CLK); #2;
        Reset        = 1'b1;
        bus.MemRead  = 1'b0;
        #1;
        check("midrst req",   bus.MemReq,   0);
        check("midrst stall", bus.MemStall, 0);
        check("midrst dout",  bus.DataMemOut, 0);
        exp_dout = 8'h00;
        @(negedge CLK);
        Reset = 1'b0;
        do_access(1'b0, 8'h41, 8'h00, 2, 8'hE7);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int d;
            d = ($urandom_range(0, 9) < 2) ? -1 : int'($urandom_range(0, TIMEOUT + 1));
            do_access(1'($urandom), 8'($urandom), 8'($urandom), d, 8'($urandom));
            repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
